// File: rtl/device_control_bank.sv
// Host register bank (CTRL/STATUS/THREAD_COUNT/ARG words) with a kernel launch
// handshake towards the dispatcher and sticky done/error reporting.
module device_control_bank #(
  parameter  int DATA_WIDTH = 8,
  parameter  int NUM_REGS   = 8,
  localparam int ADDR_WIDTH = $clog2(NUM_REGS),
  localparam int NUM_ARGS   = NUM_REGS - 3
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           wr_en,
  input  logic [ADDR_WIDTH-1:0]          wr_addr,
  input  logic [DATA_WIDTH-1:0]          wr_data,
  input  logic                           rd_en,
  input  logic [ADDR_WIDTH-1:0]          rd_addr,
  output logic [DATA_WIDTH-1:0]          rd_data,
  output logic                           rd_valid,
  output logic [DATA_WIDTH-1:0]          thread_count,
  output logic [NUM_ARGS*DATA_WIDTH-1:0] arg_regs,
  output logic                           start,
  input  logic                           start_ack,
  input  logic                           kernel_done,
  output logic                           busy
);

  typedef enum logic [1:0] {IDLE = 2'd0, LAUNCH = 2'd1, RUN = 2'd2} state_t;

  localparam logic [ADDR_WIDTH:0] NUM_REGS_W = (ADDR_WIDTH + 1)'(NUM_REGS);

  state_t                state_reg;
  logic                  start_reg;
  logic                  busy_reg;
  logic                  done_reg;
  logic                  err_reg;
  logic [DATA_WIDTH-1:0] thread_count_reg;
  logic [DATA_WIDTH-1:0] arg_reg [NUM_ARGS];
  logic [DATA_WIDTH-1:0] rd_data_reg;
  logic                  rd_valid_reg;

  logic wr_in_range;
  logic go_write;
  logic data_write;
  logic status_write;
  logic err_set;
  logic done_set;
  logic launch;
  logic [DATA_WIDTH-1:0] status_word;
  logic [DATA_WIDTH-1:0] rd_mux;

  assign wr_in_range  = {1'b0, wr_addr} < NUM_REGS_W;
  assign go_write     = wr_en && wr_in_range && (wr_addr == '0) && wr_data[0];
  assign data_write   = wr_en && wr_in_range && (wr_addr >= ADDR_WIDTH'(2));
  assign status_write = wr_en && (wr_addr == ADDR_WIDTH'(1));

  // Any write the bank refuses leaves the registers untouched and flags err.
  assign err_set  = (wr_en && !wr_in_range) || (busy_reg && (go_write || data_write));
  assign launch   = go_write && (state_reg == IDLE) && (thread_count_reg != '0);
  assign done_set = ((state_reg == RUN) && kernel_done)
                 || (go_write && (state_reg == IDLE) && (thread_count_reg == '0));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= IDLE;
      start_reg <= 1'b0;
      busy_reg  <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (launch) begin
            state_reg <= LAUNCH;
            start_reg <= 1'b1;
            busy_reg  <= 1'b1;
          end
        end
        LAUNCH: begin
          if (start_ack) begin
            state_reg <= RUN;
            start_reg <= 1'b0;
          end
        end
        RUN: begin
          if (kernel_done) begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
          end
        end
        default: begin
          state_reg <= IDLE;
          start_reg <= 1'b0;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  // Sticky flags: a set on the same edge as a W1C clear takes priority.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      done_reg <= 1'b0;
      err_reg  <= 1'b0;
    end else begin
      if (done_set)
        done_reg <= 1'b1;
      else if (status_write && wr_data[1])
        done_reg <= 1'b0;
      if (err_set)
        err_reg <= 1'b1;
      else if (status_write && wr_data[2])
        err_reg <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      thread_count_reg <= '0;
    else if (data_write && !busy_reg && (wr_addr == ADDR_WIDTH'(2)))
      thread_count_reg <= wr_data;
  end

  generate
    for (genvar gi = 0; gi < NUM_ARGS; gi++) begin : g_arg
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
          arg_reg[gi] <= '0;
        else if (data_write && !busy_reg && (wr_addr == ADDR_WIDTH'(gi + 3)))
          arg_reg[gi] <= wr_data;
      end
      assign arg_regs[gi*DATA_WIDTH +: DATA_WIDTH] = arg_reg[gi];
    end
  endgenerate

  always_comb begin
    status_word      = '0;
    status_word[2:0] = {err_reg, done_reg, busy_reg};
  end

  // CTRL reads 0 and unmapped addresses fall through to the 0 default.
  always_comb begin
    rd_mux = '0;
    if (rd_addr == ADDR_WIDTH'(1))
      rd_mux = status_word;
    else if (rd_addr == ADDR_WIDTH'(2))
      rd_mux = thread_count_reg;
    else begin
      for (int i = 0; i < NUM_ARGS; i++) begin
        if (rd_addr == ADDR_WIDTH'(i + 3))
          rd_mux = arg_reg[i];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_data_reg  <= '0;
      rd_valid_reg <= 1'b0;
    end else begin
      rd_valid_reg <= rd_en;
      if (rd_en)
        rd_data_reg <= rd_mux;
    end
  end

  assign rd_data      = rd_data_reg;
  assign rd_valid     = rd_valid_reg;
  assign thread_count = thread_count_reg;
  assign start        = start_reg;
  assign busy         = busy_reg;

endmodule
